// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for the SDRAM slave: pipelined line-fetch reads have priority, single writes fill gaps.
// Optional write-starvation guard enabled by defining ARB_WR_STARVE_GUARD_EN.
module sdram_port_arbiter #(
   parameter int unsigned LINE_WORDS = 400,
   parameter logic [24:0] FRAME_BASE = 25'h0,
   parameter int unsigned MAX_PEND   = 8
`ifdef ARB_WR_STARVE_GUARD_EN
   ,parameter int unsigned WR_STARVE_MAX = 64
`endif
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iLINE_REQ,
   input  logic [12:0] iLINE_ID,
   output logic        oLINE_BUSY,
   output logic [15:0] oLINE_DATA,
   output logic        oLINE_VALID,
   output logic        oLINE_DONE,
   output logic        oLINE_OVERRUN,
   input  logic        iWR_REQ,
   input  logic [24:0] iWR_ADDR,
   input  logic [15:0] iWR_DATA,
   output logic        oWR_ACK,
   output logic [24:0] oAV_ADDR,
   output logic        oAV_RD,
   output logic        oAV_WR,
   output logic [15:0] oAV_WRDATA,
   input  logic        iAV_WAITREQ,
   input  logic [15:0] iAV_RDDATA,
   input  logic        iAV_RDVALID
);

   typedef enum logic [1:0] {IDLE, LINE_ISSUE, LINE_DRAIN, WRITE} state_t;

   localparam logic [9:0]  LW      = 10'(LINE_WORDS);
   localparam logic [9:0]  LW_LAST = 10'(LINE_WORDS - 1);
   localparam logic [24:0] LW25    = 25'(LINE_WORDS);
   localparam logic [3:0]  PMAX    = 4'(MAX_PEND);

   state_t      state_q, state_d;
   logic [24:0] base_q, base_d;
   logic [9:0]  issued_q, issued_d;
   logic [9:0]  recv_q, recv_d;
   logic [3:0]  pend_q, pend_d;
   logic        lq_vld_q, lq_vld_d;
   logic [12:0] lq_id_q, lq_id_d;
   logic        overrun_q, overrun_d;
   logic [15:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        ack_q, ack_d;
   logic [24:0] addr_q, addr_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [15:0] wrdata_q, wrdata_d;

   logic        accept, ret;
   logic [3:0]  pend_nxt;
   logic [9:0]  issued_nxt;
   logic [12:0] lid_sel;
   logic [24:0] base_new;

`ifdef ARB_WR_STARVE_GUARD_EN
   localparam logic [15:0] STARVE_LIM = 16'(WR_STARVE_MAX);
   logic [15:0] starve_q, starve_d;
   logic        resume_q, resume_d;
`endif

   assign accept     = rd_q & ~iAV_WAITREQ;
   // Returns with nothing outstanding are stale (e.g. from before a reset) and dropped.
   assign ret        = iAV_RDVALID & (pend_q != 4'd0);
   assign pend_nxt   = pend_q + {3'd0, accept} - {3'd0, ret};
   assign issued_nxt = issued_q + {9'd0, accept};
   assign lid_sel    = lq_vld_q ? lq_id_q : iLINE_ID;
   assign base_new   = FRAME_BASE + (25'(lid_sel) * LW25);

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      issued_d  = issued_nxt;
      recv_d    = recv_q + {9'd0, ret};
      pend_d    = pend_nxt;
      lq_vld_d  = lq_vld_q;
      lq_id_d   = lq_id_q;
      overrun_d = overrun_q;
      data_d    = ret ? iAV_RDDATA : data_q;
      valid_d   = ret;
      done_d    = 1'b0;
      ack_d     = 1'b0;
      addr_d    = addr_q;
      rd_d      = 1'b0;
      wr_d      = wr_q;
      wrdata_d  = wrdata_q;
`ifdef ARB_WR_STARVE_GUARD_EN
      resume_d  = resume_q;
`endif

      if (iLINE_REQ && (state_q != IDLE)) begin
         if (!lq_vld_q) begin
            lq_vld_d = 1'b1;
            lq_id_d  = iLINE_ID;
         end else begin
            overrun_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (lq_vld_q || iLINE_REQ) begin
               base_d   = base_new;
               issued_d = 10'd0;
               recv_d   = 10'd0;
               addr_d   = base_new;
               rd_d     = 1'b1;
               state_d  = LINE_ISSUE;
               if (lq_vld_q) begin
                  lq_vld_d = iLINE_REQ;
                  lq_id_d  = iLINE_ID;
               end
            end else if (iWR_REQ && !ack_q) begin
               // The ack cycle is skipped so a requester still holding the level is not granted twice.
               state_d  = WRITE;
               wr_d     = 1'b1;
               addr_d   = iWR_ADDR;
               wrdata_d = iWR_DATA;
            end
         end
         LINE_ISSUE: begin
            if (accept && (issued_q == LW_LAST)) begin
               state_d = LINE_DRAIN;
`ifdef ARB_WR_STARVE_GUARD_EN
            end else if (accept && iWR_REQ && (starve_q >= STARVE_LIM)) begin
               state_d  = WRITE;
               wr_d     = 1'b1;
               addr_d   = iWR_ADDR;
               wrdata_d = iWR_DATA;
               resume_d = 1'b1;
`endif
            end else begin
               rd_d   = (pend_nxt < PMAX);
               addr_d = base_q + 25'(issued_nxt);
            end
         end
         LINE_DRAIN: begin
            if (recv_q == LW) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (wr_q && !iAV_WAITREQ) begin
               wr_d    = 1'b0;
               ack_d   = 1'b1;
               state_d = IDLE;
`ifdef ARB_WR_STARVE_GUARD_EN
               if (resume_q) begin
                  state_d  = LINE_ISSUE;
                  resume_d = 1'b0;
                  rd_d     = (pend_nxt < PMAX);
                  addr_d   = base_q + 25'(issued_q);
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == LINE_ISSUE) || (state_d == LINE_DRAIN) || lq_vld_d;
`ifdef ARB_WR_STARVE_GUARD_EN
      busy_d = busy_d || resume_d;
`endif
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q   <= IDLE;
         base_q    <= '0;
         issued_q  <= '0;
         recv_q    <= '0;
         pend_q    <= '0;
         lq_vld_q  <= 1'b0;
         lq_id_q   <= '0;
         overrun_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         wrdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         issued_q  <= issued_d;
         recv_q    <= recv_d;
         pend_q    <= pend_d;
         lq_vld_q  <= lq_vld_d;
         lq_id_q   <= lq_id_d;
         overrun_q <= overrun_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         addr_q    <= addr_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         wrdata_q  <= wrdata_d;
      end
   end

`ifdef ARB_WR_STARVE_GUARD_EN
   always_comb begin
      starve_d = starve_q;
      if (ack_d) begin
         starve_d = '0;
      end else if (iWR_REQ && (state_q == LINE_ISSUE) && (starve_q != 16'hFFFF)) begin
         starve_d = starve_q + 16'd1;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         starve_q <= '0;
         resume_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         resume_q <= resume_d;
      end
   end
`endif

   assign oLINE_BUSY    = busy_q;
   assign oLINE_DATA    = data_q;
   assign oLINE_VALID   = valid_q;
   assign oLINE_DONE    = done_q;
   assign oLINE_OVERRUN = overrun_q;
   assign oWR_ACK       = ack_q;
   assign oAV_ADDR      = addr_q;
   assign oAV_RD        = rd_q;
   assign oAV_WR        = wr_q;
   assign oAV_WRDATA    = wrdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a latency-programmable SDRAM slave model.
module tb_sdram_port_arbiter;

   localparam int LWORDS = 400;
   localparam int MAXP   = 8;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        iLINE_REQ = 1'b0;
   logic [12:0] iLINE_ID = '0;
   logic        oLINE_BUSY, oLINE_VALID, oLINE_DONE, oLINE_OVERRUN;
   logic [15:0] oLINE_DATA;
   logic        iWR_REQ = 1'b0;
   logic [24:0] iWR_ADDR = '0;
   logic [15:0] iWR_DATA = '0;
   logic        oWR_ACK;
   logic [24:0] oAV_ADDR;
   logic        oAV_RD, oAV_WR;
   logic [15:0] oAV_WRDATA;
   logic        iAV_WAITREQ = 1'b0;
   logic [15:0] iAV_RDDATA = '0;
   logic        iAV_RDVALID = 1'b0;

   always #5 iCLK = ~iCLK;

   sdram_port_arbiter #(
      .LINE_WORDS(LWORDS), .FRAME_BASE(25'h0), .MAX_PEND(MAXP)
`ifdef ARB_WR_STARVE_GUARD_EN
      , .WR_STARVE_MAX(16)
`endif
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .iLINE_REQ(iLINE_REQ), .iLINE_ID(iLINE_ID),
      .oLINE_BUSY(oLINE_BUSY), .oLINE_DATA(oLINE_DATA), .oLINE_VALID(oLINE_VALID),
      .oLINE_DONE(oLINE_DONE), .oLINE_OVERRUN(oLINE_OVERRUN),
      .iWR_REQ(iWR_REQ), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA), .oWR_ACK(oWR_ACK),
      .oAV_ADDR(oAV_ADDR), .oAV_RD(oAV_RD), .oAV_WR(oAV_WR), .oAV_WRDATA(oAV_WRDATA),
      .iAV_WAITREQ(iAV_WAITREQ), .iAV_RDDATA(iAV_RDDATA), .iAV_RDVALID(iAV_RDVALID)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [24:0] a);
      return a[15:0] ^ 16'h5A3C;
   endfunction

   // Slave model and monitors, all evaluated at the falling edge.
   int          lat = 3;
   int          ncyc = 0;
   logic [24:0] sq_addr[$];
   int          sq_due[$];
   int          iss_lines[$];
   int          rx_lines[$];
   int          iss_cnt_line = 0, rx_cnt_line = 0;
   int          iss_total = 0, valid_cnt = 0, done_cnt = 0, wr_cnt = 0;
   int          addr_err = 0, data_err = 0, pend_viol = 0, max_pend = 0, both_err = 0;
   int          done_cyc = 0, wr_cyc = 0;
   logic [24:0] first_rd_addr = '0, last_rd_addr = '0, wr_addr_seen = '0;
   logic [15:0] wr_data_seen = '0;

   always @(negedge iCLK) begin
      logic [24:0] ea;
      ncyc++;
      if (oAV_RD && sq_addr.size() >= MAXP) pend_viol++;
      if (sq_addr.size() > max_pend) max_pend = sq_addr.size();
      if (oAV_RD && oAV_WR) both_err++;
      if (sq_due.size() > 0 && sq_due[0] <= ncyc) begin
         iAV_RDVALID = 1'b1;
         iAV_RDDATA  = mem_word(sq_addr[0]);
         void'(sq_addr.pop_front());
         void'(sq_due.pop_front());
      end else begin
         iAV_RDVALID = 1'b0;
         iAV_RDDATA  = 16'h0;
      end
      if (oAV_RD && !iAV_WAITREQ) begin
         sq_addr.push_back(oAV_ADDR);
         sq_due.push_back(ncyc + lat);
         if (iss_total == 0) first_rd_addr = oAV_ADDR;
         last_rd_addr = oAV_ADDR;
         iss_total++;
         if (iss_lines.size() > 0) begin
            ea = 25'(iss_lines[0] * LWORDS + iss_cnt_line);
            if (oAV_ADDR !== ea) addr_err++;
            iss_cnt_line++;
            if (iss_cnt_line == LWORDS) begin
               iss_cnt_line = 0;
               void'(iss_lines.pop_front());
            end
         end else begin
            addr_err++;
         end
      end
      if (oAV_WR && !iAV_WAITREQ) begin
         wr_cnt++;
         wr_cyc       = ncyc;
         wr_addr_seen = oAV_ADDR;
         wr_data_seen = oAV_WRDATA;
      end
      if (oLINE_VALID) begin
         valid_cnt++;
         if (rx_lines.size() > 0) begin
            ea = 25'(rx_lines[0] * LWORDS + rx_cnt_line);
            if (oLINE_DATA !== mem_word(ea)) data_err++;
            rx_cnt_line++;
            if (rx_cnt_line == LWORDS) begin
               rx_cnt_line = 0;
               void'(rx_lines.pop_front());
            end
         end else begin
            data_err++;
         end
      end
      if (oLINE_DONE) begin
         done_cnt++;
         done_cyc = ncyc;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   task automatic clr_mon();
      iss_lines.delete();
      rx_lines.delete();
      iss_cnt_line = 0; rx_cnt_line = 0;
      iss_total = 0; valid_cnt = 0; done_cnt = 0; wr_cnt = 0;
      addr_err = 0; data_err = 0; pend_viol = 0; max_pend = 0;
   endtask

   task automatic line_req(input int id, input bit served);
      iLINE_ID  = 13'(id);
      iLINE_REQ = 1'b1;
      if (served) begin
         iss_lines.push_back(id);
         rx_lines.push_back(id);
      end
      cyc(1);
      iLINE_REQ = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      int k = 0;
      while (done_cnt < n && k < budget) begin
         cyc(1);
         k++;
      end
      chk("done_wait", done_cnt, n);
   endtask

   initial begin
      cyc(3);
      chk("rst_ctl", {oAV_RD, oAV_WR, oLINE_BUSY, oLINE_VALID, oLINE_DONE, oWR_ACK, oLINE_OVERRUN}, 0);
      chk("rst_addr", oAV_ADDR, 0);
      iRST_N = 1'b1;
      cyc(2);

      // Line 2 with a 3-cycle slave.
      clr_mon(); lat = 3;
      line_req(2, 1);
      chk("a_busy", oLINE_BUSY, 1);
      wait_done(1, 1500);
      chk("a_words", valid_cnt, 400);
      chk("a_data_err", data_err, 0);
      chk("a_addr_err", addr_err, 0);
      chk("a_first_addr", first_rd_addr, 800);
      chk("a_last_addr", last_rd_addr, 1199);
      cyc(2);
      chk("a_busy_end", oLINE_BUSY, 0);
      chk("a_one_done", done_cnt, 1);

      // Long latency exercises the outstanding-read limit.
      clr_mon(); lat = 20;
      line_req(5, 1);
      wait_done(1, 4000);
      chk("b_words", valid_cnt, 400);
      chk("b_data_err", data_err, 0);
      chk("b_max_pend", max_pend, MAXP);
      chk("b_pend_viol", pend_viol, 0);
      cyc(25);

      // Single write held off by waitrequest for 5 cycles.
      clr_mon(); lat = 3;
      iAV_WAITREQ = 1'b1;
      iWR_ADDR = 25'h1234; iWR_DATA = 16'hBEEF; iWR_REQ = 1'b1;
      cyc(1);
      chk("c_wr_start", oAV_WR, 1);
      for (int i = 0; i < 5; i++) begin
         chk("c_hold_addr", oAV_ADDR, 25'h1234);
         chk("c_hold_ctl", {oAV_WR, oWR_ACK, oAV_WRDATA}, {1'b1, 1'b0, 16'hBEEF});
         cyc(1);
      end
      iAV_WAITREQ = 1'b0;
      chk("c_cycle6", {oAV_WR, oWR_ACK}, 2'b10);
      cyc(1);
      chk("c_ack", {oAV_WR, oWR_ACK}, 2'b01);
      iWR_REQ = 1'b0;
      cyc(1);
      chk("c_ack_pulse", {oAV_WR, oWR_ACK}, 2'b00);
      chk("c_wr_count", wr_cnt, 1);

      // Simultaneous line and write request.
      clr_mon(); lat = 3;
      iWR_ADDR = 25'h0ABC; iWR_DATA = 16'h1357; iWR_REQ = 1'b1;
      line_req(1, 1);
      begin
         int k = 0;
         while (!oWR_ACK && k < 2000) begin
            cyc(1);
            k++;
         end
      end
      chk("d_ack", oWR_ACK, 1);
      iWR_REQ = 1'b0;
      wait_done(1, 1500);
`ifdef ARB_WR_STARVE_GUARD_EN
      chk("d_wr_mid_line", (wr_cyc < done_cyc) ? 1 : 0, 1);
`else
      chk("d_wr_after_done", (wr_cyc > done_cyc) ? 1 : 0, 1);
`endif
      chk("d_words", valid_cnt, 400);
      chk("d_data_err", data_err, 0);
      chk("d_addr_err", addr_err, 0);
      chk("d_wr", {wr_cnt[6:0], wr_addr_seen, wr_data_seen}, {7'd1, 25'h0ABC, 16'h1357});
      cyc(3);

      // Three requests during one fetch: one queued, one dropped.
      clr_mon(); lat = 3;
      line_req(3, 1);
      cyc(5);
      line_req(4, 1);
      chk("e_no_overrun", oLINE_OVERRUN, 0);
      cyc(5);
      line_req(6, 0);
      chk("e_overrun", oLINE_OVERRUN, 1);
      wait_done(2, 3000);
      chk("e_words", valid_cnt, 800);
      chk("e_data_err", data_err, 0);
      chk("e_addr_err", addr_err, 0);
      cyc(10);
      chk("e_no_third", iss_total, 800);
      chk("e_busy_end", oLINE_BUSY, 0);

      // Reset in the middle of a burst while the slave keeps returning data.
      clr_mon(); lat = 3;
      line_req(7, 1);
      begin
         int k = 0;
         while (iss_total < 100 && k < 300) begin
            cyc(1);
            k++;
         end
      end
      chk("f_100_issued", (iss_total >= 100) ? 1 : 0, 1);
      iRST_N = 1'b0;
      cyc(1);
      iRST_N = 1'b1;
      chk("f_rst_ctl", {oAV_RD, oAV_WR, oLINE_BUSY, oLINE_VALID, oLINE_DONE, oWR_ACK, oLINE_OVERRUN}, 0);
      chk("f_rst_dat", {oAV_ADDR, oLINE_DATA, oAV_WRDATA}, 0);
      valid_cnt = 0;
      cyc(10);
      chk("f_stale_valid", valid_cnt, 0);
      chk("f_slave_drained", sq_addr.size(), 0);
      clr_mon();
      line_req(1, 1);
      wait_done(1, 1500);
      chk("f_words", valid_cnt, 400);
      chk("f_data_err", data_err, 0);
      chk("f_addr_err", addr_err, 0);

      chk("rd_wr_excl", both_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
